// File: rtl/dmem_miss_controller.sv
// MEM-stage data memory sequencer: stalls on any store or load miss, runs a write-through or a
// word-by-word line fill on the backing bus, then releases the stall for one DONE cycle.
module dmem_miss_controller #(
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MEM_READ,
  input  logic             MEM_WRITE,
  input  logic [31:0]      ADDRESS,
  input  logic [31:0]      WRITE_DATA,
  input  logic             HIT,
  output logic             STALL,
  output logic             BUS_REQ,
  output logic             BUS_WE,
  output logic [31:0]      BUS_ADDR,
  output logic [31:0]      BUS_WDATA,
  input  logic             BUS_ACK,
  input  logic [31:0]      BUS_RDATA,
  output logic             FILL_EN,
  output logic [IDX_W-1:0] FILL_INDEX,
  output logic [31:0]      FILL_DATA,
  output logic             FILL_DONE,
  output logic [15:0]      MISS_COUNT
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [31:0]      LINE_MASK = ~((32'd1 << (IDX_W + 2)) - 32'd1);

  logic [1:0]       state_q, state_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      miss_count_q, miss_count_d;

  logic is_idle, is_write, is_fill;
  logic store_req, load_miss, fill_ack, last_word;

  assign is_idle   = (state_q == ST_IDLE);
  assign is_write  = (state_q == ST_WRITE);
  assign is_fill   = (state_q == ST_FILL);
  // A store wins over a simultaneous load (illegal encoding treated as a store).
  assign store_req = is_idle & MEM_WRITE;
  assign load_miss = is_idle & ~MEM_WRITE & MEM_READ & ~HIT;
  assign fill_ack  = is_fill & BUS_ACK;
  assign last_word = (idx_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    idx_d        = idx_q;
    miss_count_d = miss_count_q;
    case (state_q)
      ST_IDLE: begin
        if (store_req) begin
          state_d     = ST_WRITE;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          bus_addr_d  = ADDRESS;
          bus_wdata_d = WRITE_DATA;
        end else if (load_miss) begin
          state_d    = ST_FILL;
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_addr_d = ADDRESS & LINE_MASK;
          idx_d      = '0;
          if (miss_count_q != 16'hFFFF) begin
            miss_count_d = miss_count_q + 16'd1;
          end
        end
      end
      ST_WRITE: begin
        if (BUS_ACK) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (BUS_ACK) begin
          if (last_word) begin
            state_d   = ST_DONE;
            bus_req_d = 1'b0;
            idx_d     = '0;
          end else begin
            idx_d      = idx_q + IDX_ONE;
            bus_addr_d = bus_addr_q + 32'd4;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        idx_d     = '0;
      end
    endcase
  end

  // Reset abandons any partial fill; FILL_DONE never fired, so the line stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      idx_q        <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      idx_q        <= idx_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Stall is combinational so the pipeline cannot advance in the detect cycle.
  assign STALL      = store_req | load_miss | is_write | is_fill;
  assign BUS_REQ    = bus_req_q;
  assign BUS_WE     = bus_we_q;
  assign BUS_ADDR   = bus_addr_q;
  assign BUS_WDATA  = bus_wdata_q;
  assign FILL_EN    = fill_ack;
  assign FILL_INDEX = idx_q;
  assign FILL_DATA  = BUS_RDATA;
  assign FILL_DONE  = fill_ack & last_word;
  assign MISS_COUNT = miss_count_q;

endmodule

// File: doc/dmem_miss_controller.md
# dmem_miss_controller

Sequencing controller for the MEM stage data memory of the 32-bit RISC pipeline. It watches the load/store controls and the cache HIT flag and stalls the pipeline on a load miss or any store. It performs a write-through for stores, or a word-by-word line fill from the backing memory bus for load misses. It then releases the stall for exactly one completion cycle so the MEM stage retires the access.

## Interface

Parameters:
- WORDS_PER_LINE, 4: words per cache line; power of two, 2..16.
- IDX_W, $clog2(WORDS_PER_LINE): fill word index width.

Ports (clock and reset first):
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- MEM_READ  in  1  load in MEM stage (CONTROL[1]).
- MEM_WRITE  in  1  store in MEM stage (CONTROL[2]).
- ADDRESS  in  32  byte address (ALU_RESULT); word aligned.
- WRITE_DATA  in  32  store data (READ_DATA_2).
- HIT  in  1  cache tag match for ADDRESS, valid in the same cycle.
- STALL  out  1  freeze PC and all pipeline registers up to and including EX/MEM.
- BUS_REQ  out  1  backing-memory request, registered.
- BUS_WE  out  1  1 = write, 0 = read; registered.
- BUS_ADDR  out  32  word address, registered.
- BUS_WDATA  out  32  write data, registered.
- BUS_ACK  in  1  slave completes the current request this cycle.
- BUS_RDATA  in  32  read data, valid when BUS_ACK=1.
- FILL_EN  out  1  write FILL_DATA into the cache line word FILL_INDEX.
- FILL_INDEX  out  IDX_W  word index within the line.
- FILL_DATA  out  32  equals BUS_RDATA.
- FILL_DONE  out  1  last fill word; the cache sets tag/valid this cycle.
- MISS_COUNT  out  16  saturating count of load misses.

## Operation

- States: IDLE, WRITE, FILL, DONE. Reset state is IDLE.
- IDLE:
  - If MEM_WRITE=1, go to WRITE. This takes priority when MEM_READ is also high, which is an illegal encoding handled as a store.
  - Otherwise, if MEM_READ=1 and HIT=0, go to FILL.
  - Otherwise, stay in IDLE.
- Entry to WRITE: register BUS_REQ=1, BUS_WE=1, BUS_ADDR=ADDRESS, BUS_WDATA=WRITE_DATA.
- Entry to FILL:
  - Register BUS_REQ=1, BUS_WE=0, BUS_ADDR=line base, index counter=0.
  - Line base is ADDRESS with bits [IDX_W+1:0] cleared.
  - MISS_COUNT increments by 1 and holds at 16'hFFFF.
- WRITE: hold all BUS_* outputs stable until BUS_ACK=1. On ACK, drop BUS_REQ and go to DONE.
- FILL, each cycle with BUS_ACK=1:
  - FILL_EN=1, FILL_INDEX=counter, FILL_DATA=BUS_RDATA. These are combinational from state, counter and BUS_ACK.
  - If counter < WORDS_PER_LINE-1: increment counter, BUS_ADDR += 4, keep BUS_REQ high.
  - Else: FILL_DONE=1, drop BUS_REQ, go to DONE.
- DONE:
  - STALL=0; the MEM stage retires the access this cycle. The load now hits; the store has been written to memory, and the cache writes it on hit.
  - MEM_READ, MEM_WRITE and HIT are ignored.
  - Always go to IDLE next cycle.
- STALL = (IDLE & (MEM_WRITE | (MEM_READ & ~HIT))) | WRITE | FILL. It is combinational so the pipeline cannot advance in the detect cycle.
- Bus rules:
  - BUS_ADDR, BUS_WE and BUS_WDATA are constant while BUS_REQ=1 and no ACK has occurred.
  - The slave may hold ACK low indefinitely; the controller has no timeout.
  - BUS_ACK while BUS_REQ=0 is ignored.
- Policy: write-through, no-write-allocate. Store misses do not fill.

## Timing

- Reset values: STALL=0, BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_WDATA=0, FILL_EN=0, FILL_INDEX=0, FILL_DONE=0, MISS_COUNT=0.
- Reset mid-operation: immediately go to IDLE, drop BUS_REQ and clear the counter. A partial line is abandoned; valid is never set because FILL_DONE never fired.
- Store detected in cycle T:
  - BUS_REQ=1 from T+1.
  - With ACK in T+1 (zero wait states): DONE in T+2, STALL high in T and T+1.
  - Each slave wait state adds one stall cycle.
- Load miss detected in cycle T, with zero-wait ACKs:
  - Fill words are acknowledged in T+1..T+WORDS_PER_LINE.
  - DONE in T+WORDS_PER_LINE+1.
  - Total stall is WORDS_PER_LINE+1 cycles.
- Load hit or no access in IDLE: STALL=0, zero overhead.
- Back-to-back misses: the next detection occurs in the cycle after DONE, at the earliest 1 cycle after the release.

## Test plan

- Reset, then a load hit (MEM_READ=1, HIT=1, ADDRESS=0x100) -> STALL=0 every cycle, BUS_REQ never rises, MISS_COUNT=0.
- Load miss at ADDRESS=0x0000_1234, zero-wait slave returning 0xA0..0xA3:
  - BUS_ADDR sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - FILL_INDEX 0..3 with FILL_DATA 0xA0..0xA3.
  - FILL_DONE on the 4th ACK.
  - STALL high exactly 5 cycles; MISS_COUNT=1.
- Store 0xDEADBEEF to 0x40, slave with 3 wait states -> BUS_WE=1 and BUS_ADDR/BUS_WDATA stable for 4 cycles, STALL high for 5 cycles, then one DONE cycle with STALL=0.
- MEM_READ=1 and MEM_WRITE=1 together with HIT=0 -> a write sequence is issued, no fill, MISS_COUNT unchanged.
- rst_n pulsed low after the 2nd fill ACK -> BUS_REQ=0 and STALL=0 asynchronously. A subsequent miss restarts at FILL_INDEX=0 and the line base.
- Force 65540 load misses -> MISS_COUNT saturates at 0xFFFF.
